keccak_arbiter: RTL

KECCAK_ARBITER -- requirements
Module: keccak_arbiter

---
 rtl/keccak_pkg.sv | 19 +
 rtl/keccak_arbiter_rr_pick.sv | 31 +++
 rtl/keccak_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types and constants for the Keccak core arbiter.
//   arb_state_t        - arbiter FSM state encoding (IDLE/ABSORB/SQUEEZE/FLUSH)
//   HDR_*_BIT / HDR_*  - header-word flag positions understood by the Keccak core
package keccak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABSORB  = 2'd1,
        ST_SQUEEZE = 2'd2,
        ST_FLUSH   = 2'd3
    } arb_state_t;

    // Header word flags: bit 30 selects SHAKE256, bit 31 marks the last block.
    localparam int          HDR_SHAKE256_BIT   = 30;
    localparam int          HDR_LAST_BLOCK_BIT = 31;
    localparam logic [31:0] HDR_SHAKE256       = 32'h1 << HDR_SHAKE256_BIT;
    localparam logic [31:0] HDR_LAST_BLOCK     = 32'h1 << HDR_LAST_BLOCK_BIT;

endpackage

// File: rtl/keccak_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req        in  NUM_REQ  request vector
//   last_owner in  IDX_W    index of the previous owner; search starts one above it
//   winner     out NUM_REQ  one-hot winner, all-zero when no request is pending
module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk the ring once starting at last_owner+1; the first requester hit wins.
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = last_owner;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one Keccak core between NUM_REQ requesters.
// A job is granted in IDLE, streams input words through to the core (ABSORB),
// streams output words back (SQUEEZE) until the latched word count is used up,
// then spends one FLUSH cycle pulsing core_force_done and rsp_done[owner].
// All data/handshake paths are combinational pass-through muxes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req / grant         per-requester request, one-hot owner (0 when idle)
//   req_din*            per-requester input words, valid, last, ready
//   req_out_words       per-requester count of 32-bit output words wanted
//   rsp_dout*           core output broadcast, per-requester valid/ready
//   rsp_done / rsp_err  one-cycle end-of-job / watchdog-abort pulses
//   core_*              1:1 to keccak_top din/din_valid/din_ready/dout/
//                       dout_valid/dout_ready/force_done
//
// Optional feature: define KECCAK_ARB_TIMEOUT_EN to build a watchdog that
// forces FLUSH (with rsp_err) after TIMEOUT_CYC cycles without a handshake.
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int OUT_CNT_W   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    input  logic [NUM_REQ*32-1:0]        req_din,
    input  logic [NUM_REQ-1:0]           req_din_valid,
    input  logic [NUM_REQ-1:0]           req_din_last,
    output logic [NUM_REQ-1:0]           req_din_ready,
    input  logic [NUM_REQ*OUT_CNT_W-1:0] req_out_words,
    output logic [31:0]                  rsp_dout,
    output logic [NUM_REQ-1:0]           rsp_dout_valid,
    input  logic [NUM_REQ-1:0]           rsp_dout_ready,
    output logic [NUM_REQ-1:0]           rsp_done,
    output logic [NUM_REQ-1:0]           rsp_err,
    output logic [31:0]                  core_din,
    output logic                         core_din_valid,
    input  logic                         core_din_ready,
    input  logic [31:0]                  core_dout,
    input  logic                         core_dout_valid,
    output logic                         core_dout_ready,
    output logic                         core_force_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t             r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_force_done;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_last_owner;
    logic [OUT_CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0]     w_win;
    logic [IDX_W-1:0]       w_win_idx;
    logic [OUT_CNT_W-1:0]   w_win_words;
    logic                   w_last;
    logic                   w_in_hs;
    logic                   w_out_hs;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .winner     (w_win)
    );

    // Winner index and its requested output length, for latching in IDLE.
    always_comb begin
        w_win_idx   = '0;
        w_win_words = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx   = IDX_W'(i);
                w_win_words = req_out_words[i*OUT_CNT_W +: OUT_CNT_W];
            end
        end
    end

    // Pass-through muxes steered by the registered one-hot grant and the
    // phase; everything not owned or out of phase is held at 0.
    always_comb begin
        core_din        = '0;
        core_din_valid  = 1'b0;
        w_last          = 1'b0;
        req_din_ready   = '0;
        core_dout_ready = 1'b0;
        rsp_dout_valid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i] && r_state == ST_ABSORB) begin
                core_din         = req_din[i*32 +: 32];
                core_din_valid   = req_din_valid[i];
                w_last           = req_din_last[i];
                req_din_ready[i] = core_din_ready;
            end
            if (r_grant[i] && r_state == ST_SQUEEZE) begin
                core_dout_ready   = rsp_dout_ready[i];
                rsp_dout_valid[i] = core_dout_valid;
            end
        end
    end

    assign w_in_hs  = core_din_valid && core_din_ready;
    assign w_out_hs = core_dout_valid && core_dout_ready;

    assign rsp_dout        = core_dout;
    assign grant           = r_grant;
    assign rsp_done        = r_done;
    assign core_force_done = r_force_done;

`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0]    r_wdog;
    logic [NUM_REQ-1:0] r_err;
    assign rsp_err = r_err;
`else
    assign rsp_err = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_done       <= '0;
            r_force_done <= 1'b0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
            r_wdog       <= '0;
            r_err        <= '0;
`endif
        end else begin
            // Done/force_done/err are single-cycle pulses covering FLUSH.
            r_done       <= '0;
            r_force_done <= 1'b0;
`ifdef KECCAK_ARB_TIMEOUT_EN
            r_err        <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= w_win;
                        r_owner <= w_win_idx;
                        r_cnt   <= w_win_words;
                        r_state <= ST_ABSORB;
                    end
                end
                ST_ABSORB: begin
                    if (w_in_hs && w_last) begin
                        if (r_cnt == '0) begin
                            r_state      <= ST_FLUSH;
                            r_done       <= r_grant;
                            r_force_done <= 1'b1;
                        end else begin
                            r_state <= ST_SQUEEZE;
                        end
                    end
                end
                ST_SQUEEZE: begin
                    if (w_out_hs) begin
                        r_cnt <= r_cnt - OUT_CNT_W'(1);
                        if (r_cnt == OUT_CNT_W'(1)) begin
                            r_state      <= ST_FLUSH;
                            r_done       <= r_grant;
                            r_force_done <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_grant      <= '0;
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef KECCAK_ARB_TIMEOUT_EN
            // A hit only happens on a cycle with no handshake, so it never
            // collides with the ABSORB/SQUEEZE transitions above.
            if (r_state == ST_ABSORB || r_state == ST_SQUEEZE) begin
                if (w_in_hs || w_out_hs) begin
                    r_wdog <= '0;
                end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    r_state      <= ST_FLUSH;
                    r_done       <= r_grant;
                    r_err        <= r_grant;
                    r_force_done <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

endmodule
